db_req_arbiter: RTL



---
 rtl/db_req_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/db_req_arbiter.sv
// Two-port round-robin arbiter in front of the single KVS lookup port.
// One holding register per port; a tag FIFO routes each in-order result back to its issuer.
module db_req_arbiter #(
  parameter int KEY_SIZE  = 96,
  parameter int FLAG_SIZE = 4,
  parameter int MAX_OUT   = 8,
  parameter int OUT_W     = 3
) (
  input  logic                 clk,
  input  logic                 sys_rst_n,
  input  logic [KEY_SIZE-1:0]  p0_key,
  input  logic [FLAG_SIZE-1:0] p0_flag,
  input  logic                 p0_valid,
  output logic                 p0_ready,
  input  logic [KEY_SIZE-1:0]  p1_key,
  input  logic [FLAG_SIZE-1:0] p1_flag,
  input  logic                 p1_valid,
  output logic                 p1_ready,
  output logic                 p0_resp_valid,
  output logic [FLAG_SIZE-1:0] p0_resp_flag,
  output logic                 p1_resp_valid,
  output logic [FLAG_SIZE-1:0] p1_resp_flag,
  output logic [KEY_SIZE-1:0]  db_in_key,
  output logic [FLAG_SIZE-1:0] db_in_flag,
  output logic                 db_in_valid,
  input  logic                 db_out_valid,
  input  logic [FLAG_SIZE-1:0] db_out_flag,
  output logic [OUT_W:0]       inflight,
  output logic                 err_orphan
);

  localparam logic [OUT_W:0] MAX_CNT = (OUT_W+1)'(MAX_OUT);

  logic [1:0]           req_valid;
  logic [KEY_SIZE-1:0]  req_key [2];
  logic [FLAG_SIZE-1:0] req_flag [2];

  logic [1:0]           hold_full_q, hold_full_d;
  logic [KEY_SIZE-1:0]  hold_key_q [2];
  logic [KEY_SIZE-1:0]  hold_key_d [2];
  logic [FLAG_SIZE-1:0] hold_flag_q [2];
  logic [FLAG_SIZE-1:0] hold_flag_d [2];
  logic                 rr_last_q, rr_last_d;
  logic [MAX_OUT-1:0]   tag_q, tag_d;
  logic [OUT_W-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OUT_W:0]       inflight_q, inflight_d;
  logic                 err_orphan_q, err_orphan_d;
  logic [KEY_SIZE-1:0]  db_key_q, db_key_d;
  logic [FLAG_SIZE-1:0] db_flag_q, db_flag_d;
  logic                 db_valid_q, db_valid_d;
  logic [1:0]           resp_valid_q, resp_valid_d;
  logic [FLAG_SIZE-1:0] resp_flag_q [2];
  logic [FLAG_SIZE-1:0] resp_flag_d [2];

  logic issue, pop, winner, pop_tag;

  assign req_valid   = {p1_valid, p0_valid};
  assign req_key[0]  = p0_key;
  assign req_key[1]  = p1_key;
  assign req_flag[0] = p0_flag;
  assign req_flag[1] = p1_flag;

  // Occupancy seen by issue is the registered value, so a same-cycle pop never frees a slot.
  always_comb begin
    issue   = (hold_full_q != 2'b00) && (inflight_q < MAX_CNT);
    winner  = (hold_full_q == 2'b11) ? ~rr_last_q : hold_full_q[1];
    pop     = db_out_valid && (inflight_q != '0);
    pop_tag = tag_q[rptr_q];
  end

  always_comb begin
    hold_full_d  = hold_full_q;
    hold_key_d   = hold_key_q;
    hold_flag_d  = hold_flag_q;
    rr_last_d    = rr_last_q;
    tag_d        = tag_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    inflight_d   = inflight_q;
    db_key_d     = db_key_q;
    db_flag_d    = db_flag_q;
    db_valid_d   = issue;
    resp_valid_d = 2'b00;
    resp_flag_d  = resp_flag_q;
    err_orphan_d = err_orphan_q | (db_out_valid && (inflight_q == '0));

    // Accept only into an empty holding register; issue only drains a full one.
    for (int n = 0; n < 2; n++) begin
      if (req_valid[n] && !hold_full_q[n]) begin
        hold_full_d[n] = 1'b1;
        hold_key_d[n]  = req_key[n];
        hold_flag_d[n] = req_flag[n];
      end
    end

    if (issue) begin
      hold_full_d[winner] = 1'b0;
      db_key_d            = hold_key_q[winner];
      db_flag_d           = hold_flag_q[winner];
      rr_last_d           = winner;
      tag_d[wptr_q]       = winner;
      wptr_d              = wptr_q + 1'b1;
    end

    if (pop) begin
      resp_valid_d[pop_tag] = 1'b1;
      resp_flag_d[pop_tag]  = db_out_flag;
      rptr_d                = rptr_q + 1'b1;
    end

    case ({issue, pop})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_full_q  <= 2'b00;
      hold_key_q   <= '{default: '0};
      hold_flag_q  <= '{default: '0};
      rr_last_q    <= 1'b1;
      tag_q        <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      inflight_q   <= '0;
      err_orphan_q <= 1'b0;
      db_key_q     <= '0;
      db_flag_q    <= '0;
      db_valid_q   <= 1'b0;
      resp_valid_q <= 2'b00;
      resp_flag_q  <= '{default: '0};
    end else begin
      hold_full_q  <= hold_full_d;
      hold_key_q   <= hold_key_d;
      hold_flag_q  <= hold_flag_d;
      rr_last_q    <= rr_last_d;
      tag_q        <= tag_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      inflight_q   <= inflight_d;
      err_orphan_q <= err_orphan_d;
      db_key_q     <= db_key_d;
      db_flag_q    <= db_flag_d;
      db_valid_q   <= db_valid_d;
      resp_valid_q <= resp_valid_d;
      resp_flag_q  <= resp_flag_d;
    end
  end

  assign p0_ready      = sys_rst_n & ~hold_full_q[0];
  assign p1_ready      = sys_rst_n & ~hold_full_q[1];
  assign p0_resp_valid = resp_valid_q[0];
  assign p1_resp_valid = resp_valid_q[1];
  assign p0_resp_flag  = resp_flag_q[0];
  assign p1_resp_flag  = resp_flag_q[1];
  assign db_in_key     = db_key_q;
  assign db_in_flag    = db_flag_q;
  assign db_in_valid   = db_valid_q;
  assign inflight      = inflight_q;
  assign err_orphan    = err_orphan_q;

endmodule
